// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command parser.
//   - parser state encoding
//   - ASCII constants (command letters in lower case, CR, LF, space, digits)
//   - set-time field codes and range limits
//   - small byte-classification helpers
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIG1 = 2'd1,
        ST_DIG2 = 2'd2,
        ST_TERM = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FIELD_HOUR = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2
    } field_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_CASE  = 8'h20;  // OR-ing this folds A-Z onto a-z

    localparam logic [7:0] CHR_R = 8'h72;  // 'r' run/stop
    localparam logic [7:0] CHR_C = 8'h63;  // 'c' clear
    localparam logic [7:0] CHR_M = 8'h6D;  // 'm' mode
    localparam logic [7:0] CHR_S = 8'h73;  // 's' sensor
    localparam logic [7:0] CHR_H = 8'h68;  // 'h' set hour
    localparam logic [7:0] CHR_N = 8'h6E;  // 'n' set minute
    localparam logic [7:0] CHR_T = 8'h74;  // 't' set second

    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_blank(input logic [7:0] b);
        return is_eol(b) || (b == ASCII_SP);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer: inter-byte timeout counter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : force count to zero (byte accepted or parser idle)
//   i_enable     : count while a multi-byte command is pending
//   o_expire     : combinational; high in the cycle the count sits at
//                  TIMEOUT_CYC-1 with no clear, so the parser registers
//                  the error on the following edge
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_expire  = i_enable && !i_clear && w_at_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes single-letter commands and "<H|N|T>dd<CR|LF>"
// set-time commands from a UART byte stream. All outputs are registered and
// pulse one cycle after the rx_done that caused them.
//   clk, rst      : clock, asynchronous active-high reset
//   rx_data/done  : received byte and its one-cycle strobe
//   cmd_*         : run/clear/mode/sensor command pulses
//   set_valid     : set-time pulse; set_field/set_value hold last valid value
//   cmd_err       : parse, range or inter-byte timeout error pulse
//   echo_*        : byte echo to transmitter (echo_busy input)
// Optional feature: define UART_CMD_ECHO_EN to echo each received byte;
// otherwise echo_start/echo_data are tied to 0 and echo_busy is ignored.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       cmd_sensor,
    output logic       set_valid,
    output logic [1:0] set_field,
    output logic [6:0] set_value,
    output logic       cmd_err,
    output logic [7:0] echo_data,
    output logic       echo_start,
    input  logic       echo_busy
);

    state_t     r_state;
    field_t     r_field_pend;
    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic       r_run, r_clear, r_mode, r_sensor, r_set_valid, r_err;
    logic [1:0] r_set_field;
    logic [6:0] r_set_value;

    logic [7:0] w_lc;
    logic [6:0] w_value;
    logic [6:0] w_limit;
    logic       w_expire;
    logic       w_tmr_clear;
    logic       w_tmr_enable;

    assign w_lc    = rx_data | ASCII_CASE;
    assign w_value = 7'(r_tens) * 7'd10 + 7'(r_units);
    assign w_limit = (r_field_pend == FIELD_HOUR) ? HOUR_MAX : MINSEC_MAX;

    assign w_tmr_enable = (r_state != ST_IDLE);
    assign w_tmr_clear  = rx_done || (r_state == ST_IDLE);

    cmd_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_field_pend <= FIELD_HOUR;
            r_tens       <= '0;
            r_units      <= '0;
            r_run        <= 1'b0;
            r_clear      <= 1'b0;
            r_mode       <= 1'b0;
            r_sensor     <= 1'b0;
            r_set_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_set_field  <= '0;
            r_set_value  <= '0;
        end else begin
            r_run       <= 1'b0;
            r_clear     <= 1'b0;
            r_mode      <= 1'b0;
            r_sensor    <= 1'b0;
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;
            // A byte arriving in the expiry cycle takes priority over the timeout.
            if (rx_done) begin
                case (r_state)
                    ST_IDLE: begin
                        case (w_lc)
                            CHR_R: r_run    <= 1'b1;
                            CHR_C: r_clear  <= 1'b1;
                            CHR_M: r_mode   <= 1'b1;
                            CHR_S: r_sensor <= 1'b1;
                            CHR_H: begin r_field_pend <= FIELD_HOUR; r_state <= ST_DIG1; end
                            CHR_N: begin r_field_pend <= FIELD_MIN;  r_state <= ST_DIG1; end
                            CHR_T: begin r_field_pend <= FIELD_SEC;  r_state <= ST_DIG1; end
                            default: r_err <= !is_blank(rx_data);
                        endcase
                    end
                    ST_DIG1: begin
                        if (is_digit(rx_data)) begin
                            r_tens  <= rx_data[3:0];
                            r_state <= ST_DIG2;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DIG2: begin
                        if (is_digit(rx_data)) begin
                            r_units <= rx_data[3:0];
                            r_state <= ST_TERM;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (is_eol(rx_data) && (w_value <= w_limit)) begin
                            r_set_valid <= 1'b1;
                            r_set_field <= r_field_pend;
                            r_set_value <= w_value;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_expire) begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
            end
        end
    end

    assign cmd_run    = r_run;
    assign cmd_clear  = r_clear;
    assign cmd_mode   = r_mode;
    assign cmd_sensor = r_sensor;
    assign set_valid  = r_set_valid;
    assign set_field  = r_set_field;
    assign set_value  = r_set_value;
    assign cmd_err    = r_err;

`ifdef UART_CMD_ECHO_EN
    logic       r_echo_start;
    logic [7:0] r_echo_data;

    // A busy transmitter drops the byte; there is no echo queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_echo_start <= 1'b0;
            r_echo_data  <= '0;
        end else begin
            r_echo_start <= rx_done && !echo_busy;
            if (rx_done && !echo_busy) begin
                r_echo_data <= rx_data;
            end
        end
    end

    assign echo_start = r_echo_start;
    assign echo_data  = r_echo_data;
`else
    logic w_unused_echo_busy;

    assign w_unused_echo_busy = echo_busy;
    assign echo_start = 1'b0;
    assign echo_data  = '0;
`endif

endmodule
